// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] E0 = 8'hE0;
    localparam logic [7:0] F0 = 8'hF0;
    localparam logic [7:0] E1 = 8'hE1;

    localparam int TIMEOUT_W = 16;
    localparam int FILTER_W  = 8;

    // E1 (pause key) is followed by seven bytes that carry no key event
    localparam logic [2:0] E1_SKIP = 3'd7;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a level filter: the output only follows
// the line after FILTER consecutive samples that disagree with it.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic line_in,
    output logic level_out
);

    logic                sync1_q, sync2_q, level_q;
    logic [FILTER_W-1:0] cnt_q;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == FILTER_W'(FILTER - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_out = level_q;

endmodule

// File: rtl/ps2_key_gen.sv
// PS/2 keyboard receiver: frames bytes off the filtered lines and folds the
// E0/F0/E1 prefixes into an 11-bit key event word.
module ps2_key_gen
    import ps2_pkg::*;
#(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 4000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic        busy
);

    logic clk_lvl, dat_lvl, clk_prev_q, strobe;

    ps2_line_filter #(.FILTER(FILTER)) u_clk_filt (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .line_in  (ps2_clk_in),
        .level_out(clk_lvl)
    );

    ps2_line_filter #(.FILTER(FILTER)) u_dat_filt (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .line_in  (ps2_data_in),
        .level_out(dat_lvl)
    );

    assign strobe = clk_prev_q & ~clk_lvl;

    ps2_state_e           state_q, state_d;
    logic [7:0]           shift_q, shift_d;
    logic [2:0]           bitcnt_q, bitcnt_d;
    logic                 par_q, par_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic                 byte_vld_q, byte_vld_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        par_d      = par_q;
        tmo_d      = tmo_q;
        byte_vld_d = 1'b0;
        err_d      = 1'b0;
        if (state_q == IDLE) begin
            tmo_d = '0;
            if (strobe && !dat_lvl) begin
                state_d  = DATA;
                bitcnt_d = '0;
            end
        end else if (strobe) begin
            tmo_d = '0;
            case (state_q)
                DATA: begin
                    shift_d  = {dat_lvl, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat_lvl;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    if ((^{shift_q, par_q}) && dat_lvl) byte_vld_d = 1'b1;
                    else                                err_d      = 1'b1;
                end
            endcase
        end else if (tmo_q == TIMEOUT_W'(TIMEOUT - 1)) begin
            // a strobe on the expiry cycle is handled above, so it wins
            state_d = IDLE;
            tmo_d   = '0;
            err_d   = 1'b1;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            clk_prev_q <= 1'b1;
            state_q    <= IDLE;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            byte_vld_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            clk_prev_q <= clk_lvl;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            byte_vld_q <= byte_vld_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    // Prefix decoder: runs one cycle after the frame completes
    logic [10:0] key_q, key_d;
    logic        ext_q, ext_d, rel_q, rel_d;
    logic [2:0]  skip_q, skip_d;

    always_comb begin
        key_d  = key_q;
        ext_d  = ext_q;
        rel_d  = rel_q;
        skip_d = skip_q;
        if (err_q) begin
            ext_d  = 1'b0;
            rel_d  = 1'b0;
            skip_d = '0;
        end else if (byte_vld_q) begin
            if (skip_q != '0) begin
                skip_d = skip_q - 1'b1;
            end else if (shift_q == E0) begin
                ext_d = 1'b1;
            end else if (shift_q == F0) begin
                rel_d = 1'b1;
            end else if (shift_q == E1) begin
                skip_d = E1_SKIP;
            end else begin
                key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
                ext_d = 1'b0;
                rel_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            key_q  <= '0;
            ext_q  <= 1'b0;
            rel_q  <= 1'b0;
            skip_q <= '0;
        end else begin
            key_q  <= key_d;
            ext_q  <= ext_d;
            rel_q  <= rel_d;
            skip_q <= skip_d;
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = err_q;
    assign busy      = busy_q;

endmodule
